// File: rtl/uart_slip_decoder.sv
// SLIP (RFC 1055) byte-stream decoder to AXI4-Stream packets; 1-cycle output latency behind a one-byte hold, stalls upstream when output is full.
// Optional frame length limit with DISCARD state when SLIP_DEC_MAX_LEN_EN is defined (MAX_LEN bytes per frame).
module uart_slip_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_error
);

  localparam logic [DATA_WIDTH-1:0] C_END     = DATA_WIDTH'(8'hC0);
  localparam logic [DATA_WIDTH-1:0] C_ESC     = DATA_WIDTH'(8'hDB);
  localparam logic [DATA_WIDTH-1:0] C_ESC_END = DATA_WIDTH'(8'hDC);
  localparam logic [DATA_WIDTH-1:0] C_ESC_ESC = DATA_WIDTH'(8'hDD);

  if (DATA_WIDTH != 8 || MAX_LEN < 1) begin : g_bad_cfg
    $error("uart_slip_decoder: unsupported DATA_WIDTH or MAX_LEN");
  end

`ifdef SLIP_DEC_MAX_LEN_EN
  typedef enum logic [1:0] {ST_NORMAL, ST_ESCAPED, ST_DISCARD} state_t;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic [LEN_W-1:0] len_cnt;
`else
  typedef enum logic {ST_NORMAL, ST_ESCAPED} state_t;
`endif

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   hold_dat;
  logic                    hold_vld;
  logic                    err_flag;
  logic                    accept;
  logic                    push_req, do_push, close_req, err_set;
  logic [DATA_WIDTH-1:0]   push_dat;
  logic                    err_eff;
  logic                    load_out;

  assign s_axis_tready = rst_n & (~m_axis_tvalid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_NORMAL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_dat  = s_axis_tdata;
    close_req = 1'b0;
    err_set   = 1'b0;
    do_push   = 1'b0;
    if (accept) begin
      case (state)
        ST_NORMAL: begin
          if (s_axis_tdata == C_END)      close_req = 1'b1;
          else if (s_axis_tdata == C_ESC) state_nxt = ST_ESCAPED;
          else                            push_req  = 1'b1;
        end
        ST_ESCAPED: begin
          state_nxt = ST_NORMAL;
          if (s_axis_tdata == C_ESC_END) begin
            push_req = 1'b1;
            push_dat = C_END;
          end else if (s_axis_tdata == C_ESC_ESC) begin
            push_req = 1'b1;
            push_dat = C_ESC;
          end else if (s_axis_tdata == C_END) begin
            err_set   = 1'b1;
            close_req = 1'b1;
          end else begin
            err_set  = 1'b1;
            push_req = 1'b1;
          end
        end
`ifdef SLIP_DEC_MAX_LEN_EN
        ST_DISCARD: begin
          if (s_axis_tdata == C_END) begin
            close_req = 1'b1;
            state_nxt = ST_NORMAL;
          end
        end
`endif
        default: state_nxt = ST_NORMAL;
      endcase
    end
`ifdef SLIP_DEC_MAX_LEN_EN
    // Overflowing byte is dropped; the rest of the frame is swallowed until END.
    if (push_req && len_cnt == LEN_W'(MAX_LEN)) begin
      err_set   = 1'b1;
      state_nxt = ST_DISCARD;
    end else begin
      do_push = push_req;
    end
`else
    do_push = push_req;
`endif
  end

  assign err_eff  = err_flag | err_set;
  assign load_out = hold_vld & (do_push | close_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_error   <= 1'b0;
      hold_dat      <= '0;
      hold_vld      <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (load_out) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= hold_dat;
        m_axis_tlast  <= close_req;
        m_axis_tuser  <= close_req & err_eff;
        frame_error   <= close_req & err_eff;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (do_push) begin
        hold_dat <= push_dat;
        hold_vld <= 1'b1;
      end
      if (close_req) begin
        hold_vld <= 1'b0;
        err_flag <= 1'b0;
      end else if (err_set) begin
        err_flag <= 1'b1;
      end
    end
  end

`ifdef SLIP_DEC_MAX_LEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         len_cnt <= '0;
    else if (close_req) len_cnt <= '0;
    else if (do_push)   len_cnt <= len_cnt + LEN_W'(1);
  end
`endif

endmodule

// File: tb/tb_uart_slip_decoder.sv
// Directed table-driven bench for uart_slip_decoder, plus reset-mid-frame and length-limit sequences.
module tb_uart_slip_decoder;

`ifdef SLIP_DEC_MAX_LEN_EN
  localparam int TB_MAX_LEN = 4;
`else
  localparam int TB_MAX_LEN = 256;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       frame_error;

  uart_slip_decoder #(.DATA_WIDTH(8), .MAX_LEN(TB_MAX_LEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       dvld;
    logic       ordy;
    logic       e_srdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_last;
    logic       e_user;
    logic       e_ferr;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void add(input logic [7:0] din, input logic dvld, input logic ordy,
                              input logic e_srdy, input logic e_vld, input logic [7:0] e_dat,
                              input logic e_last, input logic e_user, input logic e_ferr);
    vec_t v;
    v.din = din; v.dvld = dvld; v.ordy = ordy; v.e_srdy = e_srdy; v.e_vld = e_vld;
    v.e_dat = e_dat; v.e_last = e_last; v.e_user = e_user; v.e_ferr = e_ferr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Drive one byte for one cycle, then check the registered outputs #1 after the edge.
  task automatic step(input string tag, input logic [7:0] b, input logic v, input logic r,
                      input logic e_vld, input logic [7:0] e_dat, input logic e_last,
                      input logic e_user, input logic e_ferr);
    s_axis_tdata = b; s_axis_tvalid = v; m_axis_tready = r;
    @(posedge clk); #1;
    chk({tag, ".vld"}, {7'd0, m_axis_tvalid}, {7'd0, e_vld});
    chk({tag, ".ferr"}, {7'd0, frame_error}, {7'd0, e_ferr});
    if (e_vld) begin
      chk({tag, ".dat"}, m_axis_tdata, e_dat);
      chk({tag, ".last"}, {7'd0, m_axis_tlast}, {7'd0, e_last});
      chk({tag, ".user"}, {7'd0, m_axis_tuser}, {7'd0, e_user});
    end
  endtask

  initial begin
    rst_n = 1'b0; s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;

    // Plain frame
    add(8'hC0,1,1, 1, 0,8'h00,0,0,0);
    add(8'h01,1,1, 1, 0,8'h00,0,0,0);
    add(8'h02,1,1, 1, 1,8'h01,0,0,0);
    add(8'h03,1,1, 1, 1,8'h02,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h03,1,0,0);
    add(8'h00,0,1, 1, 0,8'h00,0,0,0);
    // Escapes
    add(8'hC0,1,1, 1, 0,8'h00,0,0,0);
    add(8'hDB,1,1, 1, 0,8'h00,0,0,0);
    add(8'hDC,1,1, 1, 0,8'h00,0,0,0);
    add(8'hDB,1,1, 1, 0,8'h00,0,0,0);
    add(8'hDD,1,1, 1, 1,8'hC0,0,0,0);
    add(8'h55,1,1, 1, 1,8'hDB,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h55,1,0,0);
    // Bad escape
    add(8'hC0,1,1, 1, 0,8'h00,0,0,0);
    add(8'h11,1,1, 1, 0,8'h00,0,0,0);
    add(8'hDB,1,1, 1, 0,8'h00,0,0,0);
    add(8'h22,1,1, 1, 1,8'h11,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h22,1,1,1);
    add(8'h00,0,1, 1, 0,8'h00,0,0,0);
    // Back-to-back END
    add(8'hC0,1,1, 1, 0,8'h00,0,0,0);
    add(8'hC0,1,1, 1, 0,8'h00,0,0,0);
    add(8'hC0,1,1, 1, 0,8'h00,0,0,0);
    add(8'h7E,1,1, 1, 0,8'h00,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h7E,1,0,0);
    add(8'h00,0,1, 1, 0,8'h00,0,0,0);
    // ESC then END, then a clean frame
    add(8'h33,1,1, 1, 0,8'h00,0,0,0);
    add(8'hDB,1,1, 1, 0,8'h00,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h33,1,1,1);
    add(8'h00,0,1, 1, 0,8'h00,0,0,0);
    add(8'h44,1,1, 1, 0,8'h00,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h44,1,0,0);
    // Backpressure: tready low for 5 cycles
    add(8'hC0,1,1, 1, 0,8'h00,0,0,0);
    add(8'hA0,1,0, 1, 0,8'h00,0,0,0);
    add(8'hA1,1,0, 1, 1,8'hA0,0,0,0);
    add(8'hA2,1,0, 0, 1,8'hA0,0,0,0);
    add(8'hA2,1,0, 0, 1,8'hA0,0,0,0);
    add(8'hA2,1,0, 0, 1,8'hA0,0,0,0);
    add(8'hA2,1,1, 1, 1,8'hA1,0,0,0);
    add(8'hC0,1,1, 1, 1,8'hA2,1,0,0);
    add(8'h00,0,1, 1, 0,8'h00,0,0,0);
`ifdef SLIP_DEC_MAX_LEN_EN
    // Over-length frame then a clean 2-byte frame
    add(8'h01,1,1, 1, 0,8'h00,0,0,0);
    add(8'h02,1,1, 1, 1,8'h01,0,0,0);
    add(8'h03,1,1, 1, 1,8'h02,0,0,0);
    add(8'h04,1,1, 1, 1,8'h03,0,0,0);
    add(8'h05,1,1, 1, 0,8'h00,0,0,0);
    add(8'h06,1,1, 1, 0,8'h00,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h04,1,1,1);
    add(8'h07,1,1, 1, 0,8'h00,0,0,0);
    add(8'h08,1,1, 1, 1,8'h07,0,0,0);
    add(8'hC0,1,1, 1, 1,8'h08,1,0,0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld",  {7'd0, m_axis_tvalid}, 8'h00);
    chk("rst.dat",  m_axis_tdata, 8'h00);
    chk("rst.last", {7'd0, m_axis_tlast}, 8'h00);
    chk("rst.user", {7'd0, m_axis_tuser}, 8'h00);
    chk("rst.ferr", {7'd0, frame_error}, 8'h00);
    chk("rst.srdy", {7'd0, s_axis_tready}, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("post_rst.srdy", {7'd0, s_axis_tready}, 8'h01);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      s_axis_tdata = vecs[i].din; s_axis_tvalid = vecs[i].dvld; m_axis_tready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d.srdy", i), {7'd0, s_axis_tready}, {7'd0, vecs[i].e_srdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d.vld", i), {7'd0, m_axis_tvalid}, {7'd0, vecs[i].e_vld});
      chk($sformatf("v%0d.ferr", i), {7'd0, frame_error}, {7'd0, vecs[i].e_ferr});
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d.dat", i), m_axis_tdata, vecs[i].e_dat);
        chk($sformatf("v%0d.last", i), {7'd0, m_axis_tlast}, {7'd0, vecs[i].e_last});
        chk($sformatf("v%0d.user", i), {7'd0, m_axis_tuser}, {7'd0, vecs[i].e_user});
      end
    end

    // Reset mid-frame: partial frame must vanish without a tlast
    step("mr0", 8'hC0, 1, 1, 0, 8'h00, 0, 0, 0);
    step("mr1", 8'hB1, 1, 1, 0, 8'h00, 0, 0, 0);
    step("mr2", 8'hB2, 1, 1, 1, 8'hB1, 0, 0, 0);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr.rst.vld",  {7'd0, m_axis_tvalid}, 8'h00);
    chk("mr.rst.dat",  m_axis_tdata, 8'h00);
    chk("mr.rst.srdy", {7'd0, s_axis_tready}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("mr3", 8'hC0, 1, 1, 0, 8'h00, 0, 0, 0);
    step("mr4", 8'h5A, 1, 1, 0, 8'h00, 0, 0, 0);
    step("mr5", 8'hC0, 1, 1, 1, 8'h5A, 1, 0, 0);
    step("mr6", 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
